// File: rtl/fetch_unit_if.sv
// Fetch-side bus: imem address/data and the decode valid/ready queue head.
// master = fetch unit, slave = imem + decode.
interface fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus8;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_pc_plus8
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_pc_plus8
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, zero-latency imem fetch into an in-order
// queue, branch redirect with queue flush, and sticky out-of-range fetch fault.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   fetch_unit_if.master        bus,
   input  logic                branch_valid,
   input  logic [31:0]         branch_target,
   output logic                fetch_fault,
   output logic [31:0]         fault_addr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [31:0]        pc;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   logic               bad_pc;
   logic               push;
   logic               pop;
   entry_t             head;

   assign bus.imem_addr = pc;

   // Misaligned or beyond the last imem word.
   assign bad_pc = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));

   assign pop  = bus.out_valid & bus.out_ready;
   assign push = ~fetch_fault & ~bad_pc & ~branch_valid &
                 ((count < CNT_W'(DEPTH)) | pop);

   // Head fields read as zero while the queue is empty.
   assign head             = mem[rd_ptr];
   assign bus.out_valid    = (count != '0);
   assign bus.out_instr    = bus.out_valid ? head.instr : 32'h0;
   assign bus.out_pc       = bus.out_valid ? head.pc : 32'h0;
   assign bus.out_pc_plus8 = bus.out_valid ? (head.pc + 32'd8) : 32'h0;

   // Branch wins over everything: flush queue, redirect, clear fault.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fetch_fault <= 1'b0;
         fault_addr  <= 32'h0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (branch_valid) begin
         pc          <= branch_target;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fetch_fault <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: pc, instr: bus.imem_rdata};
            wr_ptr      <= wr_ptr + PTR_W'(1);
            pc          <= pc + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (bad_pc && !fetch_fault) begin
            fetch_fault <= 1'b1;
            fault_addr  <= pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued as stimulus is set up
// and checked against every accepted head; imem word i holds 0xE000_0000+i.
module tb_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        fetch_fault;
   logic [31:0] fault_addr;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_q[$];

   fetch_unit_if bus();

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .DEPTH      (2),
      .IMEM_WORDS (256)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .fetch_fault   (fetch_fault),
      .fault_addr    (fault_addr)
   );

   assign bus.imem_rdata = 32'hE000_0000 + {2'b00, bus.imem_addr[31:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Every accepted head is compared with the oldest expected PC.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready && !branch_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_pop", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [31:0] epc;
            epc = exp_q.pop_front();
            check("out_pc", bus.out_pc, epc);
            check("out_instr", bus.out_instr, 32'hE000_0000 + {2'b00, epc[31:2]});
            check("out_pc_plus8", bus.out_pc_plus8, epc + 32'd8);
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic do_branch(input logic [31:0] t);
      branch_target = t;
      branch_valid  = 1'b1;
      @(posedge clk);
      #1 branch_valid = 1'b0;
   endtask

   task automatic expect_run(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      reset_n       = 1'b1;
      branch_valid  = 1'b0;
      branch_target = 32'h0;
      bus.out_ready = 1'b1;

      // Reset values
      #1 reset_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      check("rst_fault_addr", fault_addr, 32'h0);
      check("rst_imem_addr", bus.imem_addr, 32'h0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_instr", bus.out_instr, 32'h0);

      // Streaming after reset release
      do_reset();
      expect_run(32'h0, 10);
      @(negedge clk);
      check("valid_before_first_push", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("valid_after_first_push", 32'(bus.out_valid), 32'd1);
      wait_drain(40);
      bus.out_ready = 1'b0;

      // Backpressure: queue fills, head holds at pc 0
      bus.out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_head_pc", bus.out_pc, 32'h0);
            check("bp_head_instr", bus.out_instr, 32'hE000_0000);
         end
      end
      check("bp_pc_after_fill", bus.imem_addr, 32'h8);
      @(posedge clk);
      #1;
      expect_run(32'h0, 3);
      bus.out_ready = 1'b1;
      wait_drain(20);
      bus.out_ready = 1'b0;

      // Branch while full with a same-cycle ready
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check("full_valid", 32'(bus.out_valid), 32'd1);
      check("full_pc", bus.imem_addr, 32'h8);
      expect_run(32'h40, 4);
      bus.out_ready = 1'b1;
      do_branch(32'h40);
      @(negedge clk);
      check("br_flush_valid", 32'(bus.out_valid), 32'd0);
      wait_drain(20);
      bus.out_ready = 1'b0;

      // Run off the end of imem
      do_reset();
      expect_run(32'h3F0, 4);
      do_branch(32'h3F0);
      bus.out_ready = 1'b1;
      wait_drain(20);
      check("end_fault", 32'(fetch_fault), 32'd1);
      check("end_fault_addr", fault_addr, 32'h400);
      check("end_valid_drop", 32'(bus.out_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("end_pc_hold", bus.imem_addr, 32'h400);
      check("end_fault_sticky", 32'(fetch_fault), 32'd1);

      // Misaligned branch faults, later branch recovers
      do_branch(32'h42);
      check("mis_fault_cleared", 32'(fetch_fault), 32'd0);
      @(posedge clk);
      #1;
      check("mis_fault", 32'(fetch_fault), 32'd1);
      check("mis_fault_addr", fault_addr, 32'h42);
      check("mis_no_valid", 32'(bus.out_valid), 32'd0);
      expect_run(32'h10, 3);
      do_branch(32'h10);
      check("recover_fault", 32'(fetch_fault), 32'd0);
      wait_drain(20);
      bus.out_ready = 1'b0;

      // Asynchronous reset mid-cycle with two entries queued
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      check("pre_arst_valid", 32'(bus.out_valid), 32'd1);
      check("pre_arst_pc", bus.imem_addr, 32'h8);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_pc", bus.imem_addr, 32'h0);
      check("arst_out_pc", bus.out_pc, 32'h0);
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
